board_rx_assembler: RTL and testbench
=====================================

// Module: board_rx_assembler
// PURPOSE
//  Upstream of the game FSM's remote-board path. Consumes bytes from the UART RX core and
//  assembles one framed 9x9 Go board (2-bit cells: 00 empty, 01 black, 10 white).
//  On a frame that passes all checks it commits the board atomically to board_out and
//  pulses rx_ready. The game FSM copies board_out while comm_sel & rx_ready.
// PARAMETERS
//  SYNC_BYTE       8'hA5    frame start marker
//  TIMEOUT_CYCLES  100_000  maximum idle clocks between bytes inside a frame
//  TO_W            17       timeout counter width; must satisfy 2**TO_W > TIMEOUT_CYCLES
// PORTS
//  clk_in      in   1           system clock; everything is synchronous to its rising edge
//  reset_n     in   1           asynchronous, active-low reset
//  byte_in     in   8           received byte from the UART RX core
//  byte_valid  in   1           byte_in is valid this cycle; 1-cycle strobe per byte
//  board_out   out  2x[8:0][8:0] last committed board; [row][col], row 0 is first in the frame
//  rx_ready    out  1           1-cycle pulse: board_out was updated on this edge
//  frame_err   out  1           1-cycle pulse: frame dropped (checksum, cell, pad or timeout)
//  frame_cnt   out  8           count of committed frames; wraps 255 -> 0
// BEHAVIOUR
//  Reset (async assert, sync deassert in the system)
//   - state=IDLE; board_out all 2'b00; rx_ready=0; frame_err=0; frame_cnt=0.
//   - Shadow board, byte index, XOR accumulator and timeout counter are cleared.
//   - Reset mid-frame discards the partial frame and leaves board_out empty.
//  Frame format, 23 bytes: SYNC, then D0..D20, then CK.
//   - CK = XOR of D0..D20. SYNC is not included in CK.
//   - Cell i = row*9+col (0..80) is in byte D[i/4], bits [2*(i%4)+1 : 2*(i%4)].
//   - D20 carries only cell 80, in bits [1:0]. Bits [7:2] of D20 must be 0.
//  State machine (one byte accepted per byte_valid cycle; no dead cycles)
//   - IDLE: on byte_valid with byte_in==SYNC -> PAYLOAD; clear idx, xor and error flag.
//     Any other byte is ignored with no error.
//   - PAYLOAD: on byte_valid, write the 4 cells into the shadow board; xor ^= byte; idx++.
//     Set a sticky bad flag if:
//       - any decoded cell in D0..D19 == 2'b11,
//       - cell 80 == 2'b11, or
//       - D20[7:2] != 0.
//     A byte equal to SYNC inside the payload is data. After D20 (idx==20) -> CHECK.
//   - CHECK: on byte_valid -> IDLE.
//       - If byte_in==xor and no bad flag: on the next edge, board_out <= shadow,
//         rx_ready=1 for 1 cycle, frame_cnt++.
//       - Otherwise frame_err=1 for 1 cycle and board_out is unchanged.
//  Latency: rx_ready and the new board_out are visible in the cycle after the CK strobe.
//  A SYNC byte arriving in the cycle right after CK is accepted. Back-to-back frames are legal.
//  Timeout (PAYLOAD/CHECK only)
//   - The counter clears on every byte_valid and increments on every other cycle.
//   - When it reaches TIMEOUT_CYCLES: -> IDLE, frame_err pulse, partial frame dropped.
//   - The counter is held at 0 in IDLE.
//  The shadow board is separate from board_out. board_out never shows a partial frame.
//  rx_ready and frame_err are never high in the same cycle.
// TESTING
//  1. Good frame: A5 01 {19{00}} 02 03 -> 1 cycle after CK:
//     rx_ready=1 for 1 cycle; board_out[0][0]=01, board_out[8][8]=10, all other cells 00;
//     frame_cnt=1.
//  2. Same frame with CK=04 -> frame_err pulse; board_out still equals test 1;
//     frame_cnt unchanged.
//  3. D0=C0 with correct CK=C2 (D20=02) -> frame_err; bad D20=06 with CK=07 -> frame_err.
//  4. Send A5 then 5 bytes, idle TIMEOUT_CYCLES -> frame_err.
//     Then 6 bytes of garbage (no A5) -> no pulses. Then the full frame from test 1 -> rx_ready.
//  5. Two test-1 frames with byte_valid every cycle -> two rx_ready pulses 23 cycles apart;
//     frame_cnt=2.
//  6. reset_n low at D10 of a frame, then release -> board_out all 00 and no pulse.
//     The next good frame commits normally.

Source files
------------

// File: rtl/board_rx_assembler_if.sv
// Byte stream from the UART RX core into the board assembler.
interface board_rx_if;
  logic [7:0] byte_in;
  logic       byte_valid;

  modport master (output byte_in, output byte_valid);
  modport slave  (input  byte_in, input  byte_valid);
endinterface

// File: rtl/board_rx_assembler.sv
// Assembles one framed 9x9 Go board (SYNC, D0..D20, CK) from a UART byte stream.
// A frame is committed atomically to board_out only after the checksum, every
// cell code and the D20 padding are good; otherwise it is dropped with frame_err.
module board_rx_assembler #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100_000,
  parameter int         TO_W           = 17
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  board_rx_if.slave             rx,
  output logic [8:0][8:0][1:0]  board_out,
  output logic                  rx_ready,
  output logic                  frame_err,
  output logic [7:0]            frame_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  state_t          state_r, next_state_s;
  logic [4:0]      idx_r;
  logic [7:0]      xor_r;
  logic            bad_r;
  logic [TO_W-1:0] to_cnt_r;
  logic [161:0]    shadow_r;
  logic            timeout_s;
  logic            commit_s;
  logic            drop_s;
  logic            byte_bad_s;
  logic [6:0]      cell_s [4];

  // A payload byte is bad if it encodes 2'b11 anywhere; D20 holds only cell 80 and zero padding.
  function automatic logic byte_is_bad(input logic [7:0] b, input logic last);
    logic bad;
    bad = 1'b0;
    if (last) begin
      bad = (b[1:0] == 2'b11) || (b[7:2] != 6'd0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (b[2*k +: 2] == 2'b11) begin
          bad = 1'b1;
        end else begin
          bad = bad;
        end
      end
    end
    return bad;
  endfunction

  // Cell numbers carried by the current payload byte (idx*4 + k).
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cell_s[k] = {idx_r, 2'b00} + 7'(k);
    end
  end

  // Next-state logic: frame sequencing, commit/drop decisions and the inter-byte timeout.
  always_comb begin
    next_state_s = state_r;
    commit_s     = 1'b0;
    drop_s       = 1'b0;
    timeout_s    = (state_r != IDLE) && !rx.byte_valid && (to_cnt_r == TO_LAST);
    byte_bad_s   = byte_is_bad(rx.byte_in, idx_r == 5'd20);
    case (state_r)
      IDLE: begin
        if (rx.byte_valid && (rx.byte_in == SYNC_BYTE)) begin
          next_state_s = PAYLOAD;
        end else begin
          next_state_s = IDLE;
        end
      end
      PAYLOAD: begin
        if (timeout_s) begin
          next_state_s = IDLE;
          drop_s       = 1'b1;
        end else if (rx.byte_valid && (idx_r == 5'd20)) begin
          next_state_s = CHECK;
        end else begin
          next_state_s = PAYLOAD;
        end
      end
      CHECK: begin
        if (timeout_s) begin
          next_state_s = IDLE;
          drop_s       = 1'b1;
        end else if (rx.byte_valid) begin
          next_state_s = IDLE;
          if ((rx.byte_in == xor_r) && !bad_r) begin
            commit_s = 1'b1;
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          next_state_s = CHECK;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Frame accumulation: byte index, running XOR, sticky bad flag and shadow board.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      idx_r    <= 5'd0;
      xor_r    <= 8'd0;
      bad_r    <= 1'b0;
      shadow_r <= 162'd0;
    end else if ((state_r == IDLE) && rx.byte_valid && (rx.byte_in == SYNC_BYTE)) begin
      idx_r <= 5'd0;
      xor_r <= 8'd0;
      bad_r <= 1'b0;
    end else if ((state_r == PAYLOAD) && rx.byte_valid) begin
      idx_r <= idx_r + 5'd1;
      xor_r <= xor_r ^ rx.byte_in;
      bad_r <= bad_r | byte_bad_s;
      for (int k = 0; k < 4; k++) begin
        if (cell_s[k] < 7'd81) begin
          shadow_r[{cell_s[k], 1'b0} +: 2] <= rx.byte_in[2*k +: 2];
        end
      end
    end
  end

  // Inter-byte idle counter; held at zero outside a frame and cleared by every byte.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_r <= '0;
    end else if ((state_r == IDLE) || (next_state_s == IDLE) || rx.byte_valid) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + TO_ONE;
    end
  end

  // Registered outputs: atomic board commit, result pulses and committed-frame count.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      board_out <= '0;
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      rx_ready  <= commit_s;
      frame_err <= drop_s;
      if (commit_s) begin
        board_out <= shadow_r;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_board_rx_assembler.sv
// Scoreboard bench for board_rx_assembler: every frame pushes its expected
// outcome, and a negedge monitor pops and compares on each rx_ready/frame_err.
module tb_board_rx_assembler;
  localparam int TO = 40;

  logic                 clk_in = 1'b0;
  logic                 reset_n;
  logic [8:0][8:0][1:0] board_out;
  logic                 rx_ready;
  logic                 frame_err;
  logic [7:0]           frame_cnt;

  board_rx_if rx ();

  board_rx_assembler #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO), .TO_W(6)) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .rx        (rx),
    .board_out (board_out),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic         ok;
    logic         to;
    logic [161:0] board;
    logic [7:0]   cnt;
    logic [31:0]  at;
  } exp_t;

  exp_t         sb [$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           last_byte_cyc = 0;
  int           rdy_cyc [$];
  logic [7:0]   frm [23];
  logic [161:0] model_board;
  logic [7:0]   model_cnt;

  task automatic check(input string tag, input logic [161:0] obs, input logic [161:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // cycle counter, stepped on the active edge
  always @(posedge clk_in) cyc <= cyc + 1;

  // output monitor: pop one expectation per pulse
  always @(negedge clk_in) begin
    exp_t e;
    int   d;
    if (rx_ready || frame_err) begin
      check("excl", {161'd0, rx_ready & frame_err}, 162'd0);
      if (sb.size() == 0) begin
        check("unexp_pulse", {160'd0, rx_ready, frame_err}, 162'd0);
      end else begin
        e = sb.pop_front();
        d = cyc - int'(e.at);
        check("kind", {161'd0, rx_ready}, {161'd0, e.ok});
        check("board", board_out, e.board);
        check("cnt", {154'd0, frame_cnt}, {154'd0, e.cnt});
        if (e.to) check("to_lat", {161'd0, (d >= TO) && (d <= TO + 2)}, {161'd0, 1'b1});
        else      check("lat", {130'd0, 32'(d)}, 162'd1);
        if (rx_ready) rdy_cyc.push_back(cyc);
      end
    end
  end

  task automatic drive(input logic [7:0] b);
    @(posedge clk_in);
    #1;
    rx.byte_in    = b;
    rx.byte_valid = 1'b1;
    last_byte_cyc = cyc;
  endtask

  task automatic idle(input int n);
    @(posedge clk_in);
    #1;
    rx.byte_valid = 1'b0;
    rx.byte_in    = 8'h00;
    repeat (n - 1) @(posedge clk_in);
  endtask

  task automatic push_expect(input logic ok, input logic to);
    exp_t       e;
    logic [7:0] t;
    if (ok) begin
      model_board = '0;
      for (int i = 0; i < 81; i++) begin
        t = frm[5'(1 + i / 4)] >> (2 * (i % 4));
        model_board = model_board | ({160'd0, t[1:0]} << (2 * i));
      end
      model_cnt = model_cnt + 8'd1;
    end
    e.ok    = ok;
    e.to    = to;
    e.board = model_board;
    e.cnt   = model_cnt;
    e.at    = 32'(last_byte_cyc);
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic ok);
    for (int i = 0; i < 23; i++) drive(frm[i]);
    push_expect(ok, 1'b0);
  endtask

  task automatic set_t1();
    frm[0] = 8'hA5;
    for (int i = 1; i < 23; i++) frm[i] = 8'h00;
    frm[1]  = 8'h01;
    frm[21] = 8'h02;
    frm[22] = 8'h03;
  endtask

  task automatic set_rand();
    logic [7:0] b;
    logic [7:0] x;
    frm[0] = 8'hA5;
    for (int j = 1; j < 21; j++) begin
      b = 8'h00;
      for (int k = 0; k < 4; k++) b = b | (8'($urandom_range(2)) << (2 * k));
      frm[j] = b;
    end
    frm[5]  = 8'hA5;
    frm[21] = 8'($urandom_range(2));
    x = 8'h00;
    for (int j = 1; j < 22; j++) x = x ^ frm[j];
    frm[22] = x;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((sb.size() != 0) && (k < budget)) begin
      @(posedge clk_in);
      k++;
    end
    check("drain", {130'd0, 32'(sb.size())}, 162'd0);
    sb.delete();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rdy;
    rx.byte_in    = 8'h00;
    rx.byte_valid = 1'b0;
    reset_n       = 1'b0;
    model_board   = '0;
    model_cnt     = 8'd0;
    repeat (3) @(posedge clk_in);
    #1 reset_n = 1'b1;
    idle(2);
    check("rst_board", board_out, 162'd0);
    check("rst_flags", {160'd0, rx_ready, frame_err}, 162'd0);
    check("rst_cnt", {154'd0, frame_cnt}, 162'd0);

    // 1: good frame
    set_t1();
    send_frame(1'b1);
    idle(3);
    wait_drain(10);
    check("t1_c00", {160'd0, board_out[0][0]}, {160'd0, 2'b01});
    check("t1_c88", {160'd0, board_out[8][8]}, {160'd0, 2'b10});
    check("t1_cnt", {154'd0, frame_cnt}, {154'd0, 8'd1});

    // 2: bad checksum
    set_t1();
    frm[22] = 8'h04;
    send_frame(1'b0);
    idle(3);
    wait_drain(10);
    check("t2_cnt", {154'd0, frame_cnt}, {154'd0, 8'd1});

    // 3: illegal cell code, then bad D20 padding
    set_t1();
    frm[1]  = 8'hC0;
    frm[22] = 8'hC2;
    send_frame(1'b0);
    set_t1();
    frm[21] = 8'h06;
    frm[22] = 8'h07;
    send_frame(1'b0);
    idle(3);
    wait_drain(10);

    // random good frame with SYNC value inside the payload
    set_rand();
    send_frame(1'b1);
    idle(3);
    wait_drain(10);

    // 4: timeout, garbage, recovery
    set_t1();
    for (int i = 0; i < 6; i++) drive(frm[i]);
    push_expect(1'b0, 1'b1);
    idle(1);
    wait_drain(TO + 20);
    drive(8'h00); drive(8'h11); drive(8'h22);
    drive(8'h33); drive(8'h44); drive(8'h55);
    idle(TO + 5);
    check("t4_quiet", {130'd0, 32'(sb.size())}, 162'd0);
    set_t1();
    send_frame(1'b1);
    idle(3);
    wait_drain(10);

    // 5: back-to-back frames
    n_rdy = rdy_cyc.size();
    set_t1();
    send_frame(1'b1);
    send_frame(1'b1);
    idle(3);
    wait_drain(10);
    if (rdy_cyc.size() >= n_rdy + 2)
      check("t5_gap", {130'd0, 32'(rdy_cyc[rdy_cyc.size() - 1] - rdy_cyc[rdy_cyc.size() - 2])}, 162'd23);
    else
      check("t5_pulses", {130'd0, 32'(rdy_cyc.size() - n_rdy)}, 162'd2);

    // 6: reset mid-frame
    set_rand();
    for (int i = 0; i < 12; i++) drive(frm[i]);
    @(posedge clk_in);
    #1;
    rx.byte_valid = 1'b0;
    reset_n       = 1'b0;
    model_board   = '0;
    model_cnt     = 8'd0;
    repeat (2) @(posedge clk_in);
    #1 reset_n = 1'b1;
    idle(5);
    check("t6_board", board_out, 162'd0);
    check("t6_cnt", {154'd0, frame_cnt}, 162'd0);
    check("t6_quiet", {130'd0, 32'(sb.size())}, 162'd0);
    set_t1();
    send_frame(1'b1);
    idle(3);
    wait_drain(10);
    check("t6_cnt_after", {154'd0, frame_cnt}, {154'd0, 8'd1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
